// File: rtl/bcd_to_bin.sv
// Four-digit packed BCD to 14-bit binary converter using reverse double dabble.
// One shift/adjust step per clock; invalid digits short-circuit straight to DONE with err set.
module bcd_to_bin (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bcd,
  output logic        busy,
  output logic        done,
  output logic [15:0] bin,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t      state_reg, state_next;
  logic [29:0] sr_reg;
  logic [29:0] sr_shifted;
  logic [29:0] sr_next;
  logic [3:0]  cnt_reg;
  logic [15:0] bin_reg;
  logic        err_reg;
  logic [3:0]  digit_bad;
  logic        any_bad;
  logic        last_step;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      assign digit_bad[gi] = (bcd[4*gi +: 4] > 4'd9);
      // Each nibble is corrected on its own, so no borrow can cross into its neighbour.
      assign sr_next[14 + 4*gi +: 4] = (sr_shifted[14 + 4*gi +: 4] >= 4'd8) ?
                                       (sr_shifted[14 + 4*gi +: 4] - 4'd3) :
                                        sr_shifted[14 + 4*gi +: 4];
    end
  endgenerate

  assign any_bad       = |digit_bad;
  assign sr_shifted    = {1'b0, sr_reg[29:1]};
  assign sr_next[13:0] = sr_shifted[13:0];
  assign last_step     = (cnt_reg == 4'd13);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = any_bad ? DONE : CONV;
      CONV:    if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_reg  <= '0;
      cnt_reg <= '0;
      bin_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (any_bad) begin
              err_reg <= 1'b1;
              bin_reg <= '0;
            end else begin
              sr_reg  <= {bcd, 14'b0};
              cnt_reg <= '0;
              err_reg <= 1'b0;
            end
          end
        end
        CONV: begin
          sr_reg  <= sr_next;
          cnt_reg <= cnt_reg + 4'd1;
          if (last_step) bin_reg <= {2'b00, sr_next[13:0]};
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);
  assign bin  = bin_reg;
  assign err  = err_reg;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin: a vector table of conversions plus hand-built
// sequences for mid-conversion start, reset abort, reset/start collision and held start.
module tb_bcd_to_bin;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] bcd;
  logic        busy;
  logic        done;
  logic [15:0] bin;
  logic        err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_to_bin dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bcd   (bcd),
    .busy  (busy),
    .done  (done),
    .bin   (bin),
    .err   (err)
  );

  typedef struct {
    logic [15:0] bcd;
    logic [15:0] bin;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulse start for one edge, then follow the conversion to its done pulse.
  task automatic run_vec(input logic [15:0] v, input logic [15:0] ebin,
                         input logic eerr, input int elat);
    int e, busy_cnt, done_at;
    logic [15:0] got_bin;
    logic got_err;
    @(negedge clk);
    start = 1'b1;
    bcd   = v;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    bcd   = 16'h0000;
    e = 0; busy_cnt = 0; done_at = -1; got_bin = '0; got_err = 1'b0;
    while (e < 40) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_at = e; got_bin = bin; got_err = err;
        break;
      end
      @(posedge clk);
      @(negedge clk);
      e++;
    end
    chk($sformatf("latency[%h]", v), done_at, elat);
    chk($sformatf("bin[%h]", v), got_bin, ebin);
    chk($sformatf("err[%h]", v), got_err, eerr);
    chk($sformatf("busy_cycles[%h]", v), busy_cnt, elat + 1);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("done_drop[%h]", v), done, 0);
    chk($sformatf("idle[%h]", v), busy, 0);
    chk($sformatf("bin_hold[%h]", v), bin, ebin);
    $display("vec bcd=%h bin=%h err=%0d lat=%0d", v, got_bin, got_err, done_at);
  endtask

  initial begin
    int e, dones, done_at, first_done, second_done;
    logic [15:0] got_bin;

    vecs[0]  = '{16'h9999, 16'h270F, 1'b0, 14};
    vecs[1]  = '{16'h1234, 16'h04D2, 1'b0, 14};
    vecs[2]  = '{16'h0000, 16'h0000, 1'b0, 14};
    vecs[3]  = '{16'h12A4, 16'h0000, 1'b1, 0};
    vecs[4]  = '{16'h0001, 16'h0001, 1'b0, 14};
    vecs[5]  = '{16'h1000, 16'h03E8, 1'b0, 14};
    vecs[6]  = '{16'h0999, 16'h03E7, 1'b0, 14};
    vecs[7]  = '{16'hF000, 16'h0000, 1'b1, 0};
    vecs[8]  = '{16'h8765, 16'h223D, 1'b0, 14};
    vecs[9]  = '{16'h000A, 16'h0000, 1'b1, 0};
    vecs[10] = '{16'h0042, 16'h002A, 1'b0, 14};
    vecs[11] = '{16'h0500, 16'h01F4, 1'b0, 14};

    rst = 1'b1; start = 1'b0; bcd = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_bin", bin, 0);
    chk("reset_err", err, 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      run_vec(vecs[i].bcd, vecs[i].bin, vecs[i].err, vecs[i].lat);

    // Start at E0 with 0x0500, then a second start with new bcd at E5 must be ignored.
    @(negedge clk);
    start = 1'b1; bcd = 16'h0500;
    dones = 0; done_at = -1; got_bin = '0;
    for (e = 0; e < 30; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin dones++; done_at = e; got_bin = bin; end
      if (e + 1 == 5) begin start = 1'b1; bcd = 16'h9999; end
      else            begin start = 1'b0; bcd = 16'h0000; end
    end
    chk("ign_start_dones", dones, 1);
    chk("ign_start_lat", done_at, 14);
    chk("ign_start_bin", got_bin, 16'h01F4);
    $display("seq ignored-start dones=%0d bin=%h", dones, got_bin);

    // Reset at E7 aborts 0x4321 with no done pulse.
    @(negedge clk);
    start = 1'b1; bcd = 16'h4321;
    dones = 0;
    for (e = 0; e < 25; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) dones++;
      start = 1'b0;
      rst = (e + 1 == 7);
    end
    chk("abort_dones", dones, 0);
    chk("abort_busy", busy, 0);
    chk("abort_bin", bin, 0);
    chk("abort_err", err, 0);
    $display("seq reset-abort dones=%0d bin=%h busy=%0d", dones, bin, busy);
    run_vec(16'h0042, 16'h002A, 1'b0, 14);

    // Reset and start together: start ignored.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; bcd = 16'h0123;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", busy, 0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_start_busy2", busy, 0);
    $display("seq rst+start busy=%0d", busy);

    // Held start re-accepts on the first IDLE cycle after DONE: 16-cycle period.
    @(negedge clk);
    start = 1'b1; bcd = 16'h0001;
    first_done = -1; second_done = -1;
    for (e = 0; e < 40; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        if (first_done < 0) first_done = e;
        else if (second_done < 0) second_done = e;
      end
    end
    start = 1'b0;
    chk("held_first", first_done, 14);
    chk("held_period", second_done - first_done, 16);
    $display("seq held-start first=%0d second=%0d", first_done, second_done);
    repeat (20) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin.md
BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 bcd  input  16  four packed BCD digits, [15:12] thousands down to [3:0] ones.
REQ-006 busy  output  1  high in every state other than IDLE.
REQ-007 done  output  1  one-cycle pulse; bin and err are valid in that cycle.
REQ-008 bin  output  16  binary result; [15:14] always 0, maximum value 9999 (0x270F).
REQ-009 err  output  1  high when the last accepted bcd held any digit greater than 9.

Function
REQ-010 FSM states SHALL be IDLE, CONV and DONE.
REQ-011 Transitions SHALL be:
- IDLE -> CONV on start with valid digits.
- IDLE -> DONE on start with any invalid digit.
- CONV -> DONE after the 14th step.
- DONE -> IDLE unconditionally.
REQ-012 Start-accept edge with all digits <= 9:
- load a 30-bit shift register as {bcd, 14'b0}
- clear the 4-bit step counter
- clear err
- enter CONV.
REQ-013 Start-accept edge with any nibble > 9:
- set err=1 and bin=0
- enter DONE without converting.
REQ-014 Each CONV edge SHALL perform exactly one step:
- shift the 30-bit register right by 1 (MSB filled with 0)
- then subtract 3 from each of the four BCD nibbles, bits [29:14], whose value is >= 8
- increment the step counter.
REQ-015 On the edge completing step 14 (counter == 13), the block SHALL load bin from the register's low 14 bits with [15:14] = 0, and enter DONE.
REQ-016 done SHALL equal (state == DONE); it is high for exactly one cycle per accepted start.
REQ-017 Latency, counting from the start-accept edge E0:
- valid input: done high in the cycle after edge E14.
- invalid input: done high in the cycle after E0.
REQ-018 bin and err SHALL hold their last values from DONE until the next DONE.
REQ-019 A start asserted in CONV or DONE SHALL be ignored, not queued.
REQ-020 bcd SHALL be captured only at the start-accept edge; later changes SHALL NOT affect an ongoing conversion.
REQ-021 A start held high continuously SHALL be accepted again on the first IDLE cycle after DONE; the minimum start-to-start period is 16 cycles for valid input.
REQ-022 All arithmetic SHALL be unsigned; nibble adjustment SHALL never borrow across nibble boundaries.

Reset
REQ-023 With rst high at a clock edge, the block SHALL enter IDLE and clear all of the following: busy, done, bin (0x0000), err, step counter and shift register.
REQ-024 rst SHALL take priority over start and over any in-progress conversion; the aborted conversion SHALL produce no done pulse.
REQ-025 If rst and start are both high at the same edge, start SHALL be ignored.

Verification
REQ-026 bcd=0x9999, 1-cycle start -> busy high for 15 cycles; done in the cycle after E14; bin=0x270F; err=0.
REQ-027 bcd=0x1234, then bcd=0x0000 -> bin=0x04D2 then bin=0x0000; each with one done pulse and err=0.
REQ-028 bcd=0x12A4, start -> done in the cycle after E0; err=1; bin=0x0000; no CONV cycles.
REQ-029 bcd=0x0500 with start, then bcd changed to 0x9999 and start pulsed again at E5 -> single done with bin=0x01F4; second start ignored.
REQ-030 Start 0x4321, then rst at E7 -> IDLE, bin=0, no done; a new start 0x0042 then yields bin=0x002A after 14 cycles.
